// File: rtl/core_pkg.sv
// Shared encodings for the multi-cycle integer core: RV32I opcode and funct fields,
// the ALU operation set and the FETCH/EXEC/WB sequencing states.
package core_pkg;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
      ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_FETCH, ST_EXEC, ST_WB
   } state_e;

endpackage

// File: rtl/core_alu.sv
// Combinational XLEN-wide ALU; the zero flag lets the core resolve BEQ/BNE from a SUB.
module core_alu
   import core_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] i_op_a,
   input  logic [XLEN-1:0] i_op_b,
   input  alu_op_e         i_alu_op,
   output logic [XLEN-1:0] o_result,
   output logic            o_zero
);
   localparam int SW = $clog2(XLEN);

   logic [SW-1:0] w_shamt;
   assign w_shamt = i_op_b[SW-1:0];

   always_comb begin
      // NOTE: defaulting o_result before the case keeps every path assigned, so no latch is inferred.
      o_result = '0;
      case (i_alu_op)
         ALU_ADD:   o_result = i_op_a + i_op_b;
         ALU_SUB:   o_result = i_op_a - i_op_b;
         ALU_SLL:   o_result = i_op_a << w_shamt;
         ALU_SLT:   o_result = {{(XLEN-1){1'b0}}, $signed(i_op_a) < $signed(i_op_b)};
         ALU_SLTU:  o_result = {{(XLEN-1){1'b0}}, i_op_a < i_op_b};
         ALU_XOR:   o_result = i_op_a ^ i_op_b;
         ALU_SRL:   o_result = i_op_a >> w_shamt;
         ALU_SRA:   o_result = $signed(i_op_a) >>> w_shamt;
         ALU_OR:    o_result = i_op_a | i_op_b;
         ALU_AND:   o_result = i_op_a & i_op_b;
         ALU_PASSB: o_result = i_op_b;
         default:   o_result = '0;
      endcase
   end

   assign o_zero = (o_result == '0);

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle RV32I-subset core: one instruction per handshake, sequenced FETCH -> EXEC -> WB.
// Register file and decode are inline; arithmetic lives in core_alu.
module multicycle_core
   import core_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              NREGS    = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            instr_valid,
   input  logic [31:0]     instr,
   output logic            instr_ready,
   output logic [XLEN-1:0] pc_address,
   output logic [XLEN-1:0] alu_output,
   output logic [XLEN-1:0] reg1_output,
   output logic            retire,
   output logic            illegal
);
   localparam int         RW      = $clog2(NREGS);
   localparam int         SW      = $clog2(XLEN);
   localparam logic [5:0] NREGS_L = 6'(NREGS);

   state_e            r_state;
   logic [31:0]       r_ir;
   logic [XLEN-1:0]   r_pc;
   logic [XLEN-1:0]   r_alu;
   logic [XLEN-1:0]   r_regs [NREGS];
   logic              r_taken;
   logic              r_wr;
   logic              r_retire;
   logic              r_illegal;

   logic [6:0]        w_opcode;
   logic [2:0]        w_funct3;
   logic [6:0]        w_funct7;
   logic [4:0]        w_rd;
   logic              w_rd_ok, w_rs1_ok, w_rs2_ok;
   logic              w_shift_hi_zero;
   logic [XLEN-1:0]   w_imm_i, w_imm_u, w_imm_b;
   logic [XLEN-1:0]   w_rs1_val, w_rs2_val, w_op_b;
   logic [XLEN-1:0]   w_alu_result;
   logic              w_alu_zero;
   alu_op_e           w_alu_op;
   logic              w_writes, w_legal, w_is_branch, w_taken;

   assign w_opcode = r_ir[6:0];
   assign w_rd     = r_ir[11:7];
   assign w_funct3 = r_ir[14:12];
   assign w_funct7 = r_ir[31:25];

   assign w_rd_ok  = {1'b0, w_rd}        < NREGS_L;
   assign w_rs1_ok = {1'b0, r_ir[19:15]} < NREGS_L;
   assign w_rs2_ok = {1'b0, r_ir[24:20]} < NREGS_L;

   // Shift immediates: everything above the shamt field must be zero except bit 30 (arithmetic select).
   assign w_shift_hi_zero = (r_ir[31] == 1'b0) && (r_ir[29:20+SW] == '0);

   assign w_imm_i = XLEN'($signed(r_ir[31:20]));
   assign w_imm_u = XLEN'($signed({r_ir[31:12], 12'b0}));
   assign w_imm_b = XLEN'($signed({r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0}));

   assign w_rs1_val = r_regs[r_ir[15 +: RW]];
   assign w_rs2_val = r_regs[r_ir[20 +: RW]];

   always_comb begin
      w_alu_op    = ALU_ADD;
      w_op_b      = w_rs2_val;
      w_writes    = 1'b0;
      w_legal     = 1'b0;
      w_is_branch = 1'b0;
      case (w_opcode)
         OPC_OP_IMM: begin
            w_op_b   = w_imm_i;
            w_writes = 1'b1;
            w_legal  = w_rd_ok && w_rs1_ok;
            case (w_funct3)
               F3_ADD:  w_alu_op = ALU_ADD;
               F3_SLT:  w_alu_op = ALU_SLT;
               F3_SLTU: w_alu_op = ALU_SLTU;
               F3_XOR:  w_alu_op = ALU_XOR;
               F3_OR:   w_alu_op = ALU_OR;
               F3_AND:  w_alu_op = ALU_AND;
               F3_SLL: begin
                  w_alu_op = ALU_SLL;
                  w_legal  = w_legal && w_shift_hi_zero && !r_ir[30];
               end
               default: begin
                  w_alu_op = r_ir[30] ? ALU_SRA : ALU_SRL;
                  w_legal  = w_legal && w_shift_hi_zero;
               end
            endcase
         end
         OPC_OP: begin
            w_writes = 1'b1;
            w_legal  = w_rd_ok && w_rs1_ok && w_rs2_ok;
            if (w_funct7 == F7_BASE) begin
               case (w_funct3)
                  F3_ADD:  w_alu_op = ALU_ADD;
                  F3_SLL:  w_alu_op = ALU_SLL;
                  F3_SLT:  w_alu_op = ALU_SLT;
                  F3_SLTU: w_alu_op = ALU_SLTU;
                  F3_XOR:  w_alu_op = ALU_XOR;
                  F3_SR:   w_alu_op = ALU_SRL;
                  F3_OR:   w_alu_op = ALU_OR;
                  default: w_alu_op = ALU_AND;
               endcase
            end else if (w_funct7 == F7_ALT && w_funct3 == F3_ADD) begin
               w_alu_op = ALU_SUB;
            end else if (w_funct7 == F7_ALT && w_funct3 == F3_SR) begin
               w_alu_op = ALU_SRA;
            end else begin
               w_legal = 1'b0;
            end
         end
         OPC_LUI: begin
            w_op_b   = w_imm_u;
            w_alu_op = ALU_PASSB;
            w_writes = 1'b1;
            w_legal  = w_rd_ok;
         end
         OPC_BRANCH: begin
            w_alu_op    = ALU_SUB;
            w_is_branch = 1'b1;
            w_legal     = w_rs1_ok && w_rs2_ok && (w_funct3 == F3_BEQ || w_funct3 == F3_BNE);
         end
         default: ;
      endcase
   end

   core_alu #(.XLEN(XLEN)) u_alu (
      .i_op_a   (w_rs1_val),
      .i_op_b   (w_op_b),
      .i_alu_op (w_alu_op),
      .o_result (w_alu_result),
      .o_zero   (w_alu_zero)
   );

   assign w_taken = w_is_branch && w_legal && ((w_funct3 == F3_BEQ) ? w_alu_zero : !w_alu_zero);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_FETCH;
         r_ir      <= '0;
         r_pc      <= RESET_PC;
         r_alu     <= '0;
         r_taken   <= 1'b0;
         r_wr      <= 1'b0;
         r_retire  <= 1'b0;
         r_illegal <= 1'b0;
         // NOTE: the register file is reset on purpose; every xN must read zero after reset.
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else begin
         // NOTE: non-blocking updates so every state element samples pre-edge values;
         // retire/illegal default low here to form one-cycle pulses.
         r_retire  <= 1'b0;
         r_illegal <= 1'b0;
         case (r_state)
            ST_FETCH: begin
               if (instr_valid) begin
                  r_ir    <= instr;
                  r_state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (w_legal) r_alu <= w_alu_result;
               r_taken   <= w_taken;
               r_wr      <= w_legal && w_writes && (w_rd != 5'd0);
               r_retire  <= 1'b1;
               r_illegal <= !w_legal;
               r_state   <= ST_WB;
            end
            ST_WB: begin
               if (r_wr) r_regs[r_ir[7 +: RW]] <= r_alu;
               r_pc    <= r_pc + (r_taken ? w_imm_b : XLEN'(4));
               r_state <= ST_FETCH;
            end
            default: r_state <= ST_FETCH;
         endcase
      end
   end

   assign instr_ready = (r_state == ST_FETCH) && !rst;
   assign pc_address  = r_pc;
   assign alu_output  = r_alu;
   assign reg1_output = r_regs[1];
   assign retire      = r_retire;
   assign illegal     = r_illegal;

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: a 32-bit/32-register instance and a 64-bit/16-register instance
// driven by directed and $urandom instructions, checked against an architectural model.
module tb_multicycle_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [63:0] B_RESET_PC = 64'hFFFF_FFFF_FFFF_FFFC;

   logic        a_rst = 1'b1, a_valid = 1'b0;
   logic [31:0] a_instr = '0;
   logic        a_ready, a_retire, a_illegal;
   logic [31:0] a_pc, a_alu, a_x1;

   logic        b_rst = 1'b1, b_valid = 1'b0;
   logic [31:0] b_instr = '0;
   logic        b_ready, b_retire, b_illegal;
   logic [63:0] b_pc, b_alu, b_x1;

   multicycle_core #(.XLEN(32), .NREGS(32), .RESET_PC(32'h0)) u_a (
      .clk(clk), .rst(a_rst), .instr_valid(a_valid), .instr(a_instr), .instr_ready(a_ready),
      .pc_address(a_pc), .alu_output(a_alu), .reg1_output(a_x1), .retire(a_retire), .illegal(a_illegal)
   );

   multicycle_core #(.XLEN(64), .NREGS(16), .RESET_PC(B_RESET_PC)) u_b (
      .clk(clk), .rst(b_rst), .instr_valid(b_valid), .instr(b_instr), .instr_ready(b_ready),
      .pc_address(b_pc), .alu_output(b_alu), .reg1_output(b_x1), .retire(b_retire), .illegal(b_illegal)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Architectural model state; values are kept sign-extended to 64 bits for both widths.
   logic [63:0] m_regs [2][32];
   logic [63:0] m_pc   [2];
   logic [63:0] m_alu  [2];
   time         last_ret_time;

   typedef struct {
      bit          legal;
      bit          wr;
      int          rd;
      logic [63:0] res;
      logic [63:0] npc;
   } eff_t;

   function automatic int xlen_of(int core);  return core == 0 ? 32 : 64; endfunction
   function automatic int nregs_of(int core); return core == 0 ? 32 : 16; endfunction

   function automatic logic [63:0] fitx(logic [63:0] v, int xlen);
      return (xlen == 32) ? {{32{v[31]}}, v[31:0]} : v;
   endfunction

   function automatic logic [63:0] lo(int core, logic [63:0] v);
      return (core == 0) ? {32'b0, v[31:0]} : v;
   endfunction

   function automatic logic        cur_ready(int core);   return core == 0 ? a_ready   : b_ready;   endfunction
   function automatic logic        cur_retire(int core);  return core == 0 ? a_retire  : b_retire;  endfunction
   function automatic logic        cur_illegal(int core); return core == 0 ? a_illegal : b_illegal; endfunction
   function automatic logic [63:0] cur_pc(int core);      return core == 0 ? {32'b0, a_pc}  : b_pc;  endfunction
   function automatic logic [63:0] cur_alu(int core);     return core == 0 ? {32'b0, a_alu} : b_alu; endfunction
   function automatic logic [63:0] cur_x1(int core);      return core == 0 ? {32'b0, a_x1}  : b_x1;  endfunction

   function automatic eff_t effect(logic [31:0] ins, logic [63:0] a, logic [63:0] rs2v,
                                   logic [63:0] pc, int xlen, int nregs);
      eff_t        e;
      int          rd, r1, r2, sh, hi, arith_hi;
      bit          is_op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [63:0] imm_i, imm_u, imm_b, b, a_lo;
      rd    = int'(ins[11:7]);
      r1    = int'(ins[19:15]);
      r2    = int'(ins[24:20]);
      f3    = ins[14:12];
      f7    = ins[31:25];
      imm_i = {{52{ins[31]}}, ins[31:20]};
      imm_u = {{32{ins[31]}}, ins[31:12], 12'b0};
      imm_b = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      a_lo  = (xlen == 32) ? {32'b0, a[31:0]} : a;
      e.legal = 0; e.wr = 0; e.rd = rd; e.res = '0; e.npc = pc + 64'd4;
      case (ins[6:0])
         7'b0010011, 7'b0110011: begin
            is_op = (ins[6:0] == 7'b0110011);
            b     = is_op ? rs2v : imm_i;
            sh    = int'(b[5:0]) & (xlen - 1);
            e.wr  = 1;
            e.legal = (rd < nregs) && (r1 < nregs) && (!is_op || r2 < nregs);
            hi       = (xlen == 32) ? int'(ins[31:25]) : int'(ins[31:26]);
            arith_hi = (xlen == 32) ? 32 : 16;
            if (is_op)
               e.legal = e.legal && (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            else if (f3 == 3'd1)
               e.legal = e.legal && (hi == 0);
            else if (f3 == 3'd5)
               e.legal = e.legal && (hi == 0 || hi == arith_hi);
            case (f3)
               3'd0: e.res = (is_op && f7 == 7'h20) ? a - b : a + b;
               3'd1: e.res = a << sh;
               3'd2: e.res = {63'b0, $signed(a) < $signed(b)};
               3'd3: e.res = {63'b0, a < b};
               3'd4: e.res = a ^ b;
               3'd5: e.res = ins[30] ? 64'($signed(a) >>> sh) : a_lo >> sh;
               3'd6: e.res = a | b;
               default: e.res = a & b;
            endcase
         end
         7'b0110111: begin
            e.wr = 1; e.legal = (rd < nregs); e.res = imm_u;
         end
         7'b1100011: begin
            e.legal = (r1 < nregs) && (r2 < nregs) && (f3 == 3'd0 || f3 == 3'd1);
            e.res   = a - rs2v;
            if (e.legal && ((f3 == 3'd0) ? (a == rs2v) : (a != rs2v))) e.npc = pc + imm_b;
         end
         default: ;
      endcase
      e.res = fitx(e.res, xlen);
      e.npc = fitx(e.npc, xlen);
      return e;
   endfunction

   function automatic logic [31:0] enc_i(logic [11:0] imm, int rs1, int f3, int rd, logic [6:0] opc);
      return {imm, 5'(rs1), 3'(f3), 5'(rd), opc};
   endfunction
   function automatic logic [31:0] enc_r(logic [6:0] f7, int rs2, int rs1, int f3, int rd);
      return {f7, 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
   endfunction
   function automatic logic [31:0] enc_b(logic [12:0] off, int rs1, int rs2, int f3);
      return {off[12], off[10:5], 5'(rs2), 5'(rs1), 3'(f3), off[4:1], off[11], 7'b1100011};
   endfunction

   function automatic int pick_reg(int core);
      if ($urandom_range(0, 3) != 0) return $urandom_range(0, 3);
      return $urandom_range(0, core == 0 ? 31 : 19);
   endfunction

   function automatic logic [31:0] rand_instr(int core);
      int          kind = $urandom_range(0, 9);
      int          rd = pick_reg(core), r1 = pick_reg(core), r2 = pick_reg(core);
      int          f3 = $urandom_range(0, 7);
      logic [11:0] imm = 12'($urandom);
      logic [6:0]  f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      bit          arith = ($urandom_range(0, 1) != 0) && (f3 == 5);
      case (kind)
         0, 1, 2: begin
            if (f3 == 1 || f3 == 5) begin
               if (core == 0) imm[11:5] = arith ? 7'h20 : 7'h00;
               else           imm[11:6] = arith ? 6'h10 : 6'h00;
               if ($urandom_range(0, 7) == 0) imm[11:5] = 7'($urandom);
            end
            return enc_i(imm, r1, f3, rd, 7'b0010011);
         end
         3, 4, 5: begin
            if ($urandom_range(0, 7) == 0) f7 = 7'($urandom);
            return enc_r(f7, r2, r1, f3, rd);
         end
         6:       return {20'($urandom), 5'(rd), 7'b0110111};
         7, 8:    return enc_b(13'($urandom_range(0, 255)) << 1, r1, r2,
                               ($urandom_range(0, 7) == 0) ? f3 : $urandom_range(0, 1));
         default: return $urandom;
      endcase
   endfunction

   task automatic reset_model(int core);
      for (int i = 0; i < 32; i++) m_regs[core][i] = '0;
      m_pc[core]  = (core == 0) ? 64'd0 : B_RESET_PC;
      m_alu[core] = '0;
   endtask

   // Handshake one instruction and check the retire timing and architectural effect.
   task automatic issue(int core, logic [31:0] ins);
      eff_t e;
      @(negedge clk);
      for (int i = 0; i < 20 && !cur_ready(core); i++) @(negedge clk);
      check("ready_wait", cur_ready(core), 1);
      if (core == 0) begin a_valid = 1'b1; a_instr = ins; end
      else           begin b_valid = 1'b1; b_instr = ins; end
      e = effect(ins, m_regs[core][ins[19:15]], m_regs[core][ins[24:20]], m_pc[core],
                 xlen_of(core), nregs_of(core));
      @(posedge clk); #1;
      if (core == 0) a_valid = 1'b0; else b_valid = 1'b0;
      check("exec_ready", cur_ready(core), 0);
      check("exec_retire", cur_retire(core), 0);
      @(posedge clk); #1;
      last_ret_time = $time;
      check("wb_retire", cur_retire(core), 1);
      check("wb_illegal", cur_illegal(core), e.legal ? 0 : 1);
      check("wb_ready", cur_ready(core), 0);
      check("wb_pc_hold", cur_pc(core), lo(core, m_pc[core]));
      if (e.legal) m_alu[core] = e.res;
      if (e.legal && e.wr && e.rd != 0) m_regs[core][e.rd] = e.res;
      m_pc[core] = e.npc;
      @(posedge clk); #1;
      check("done_retire", cur_retire(core), 0);
      check("done_ready", cur_ready(core), 1);
      check("pc", cur_pc(core), lo(core, m_pc[core]));
      check("alu", cur_alu(core), lo(core, m_alu[core]));
      check("x1", cur_x1(core), lo(core, m_regs[core][1]));
   endtask

   task automatic do_reset(int core);
      @(negedge clk);
      if (core == 0) begin a_rst = 1'b1; a_valid = 1'b1; a_instr = 32'h0050_0093; end
      else           begin b_rst = 1'b1; b_valid = 1'b1; b_instr = 32'h0050_0093; end
      reset_model(core);
      repeat (2) begin
         @(posedge clk); @(negedge clk);
         check("rst_ready", cur_ready(core), 0);
         check("rst_pc", cur_pc(core), lo(core, m_pc[core]));
         check("rst_alu", cur_alu(core), 0);
         check("rst_retire", cur_retire(core), 0);
      end
      if (core == 0) begin a_rst = 1'b0; a_valid = 1'b0; end
      else           begin b_rst = 1'b0; b_valid = 1'b0; end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] pc_before;
      time         t0;

      do_reset(0);
      issue(0, 32'h0050_0093);
      check("addi_x1", a_x1, 32'd5);
      issue(0, enc_i(12'hFFD, 0, 0, 2, 7'b0010011));
      t0 = last_ret_time;
      issue(0, enc_r(7'h20, 2, 1, 0, 3));
      check("retire_spacing", 64'(last_ret_time - t0), 64'd30);
      check("sub_alu", a_alu, 32'd8);
      check("three_pc", a_pc, 32'd12);

      pc_before = m_pc[0];
      issue(0, enc_b(13'd16, 1, 1, 0));
      check("beq_taken", a_pc, 32'(pc_before + 64'd16));
      pc_before = m_pc[0];
      issue(0, enc_b(13'd16, 1, 1, 1));
      check("bne_not_taken", a_pc, 32'(pc_before + 64'd4));
      check("branch_no_write", a_x1, 32'd5);

      issue(0, enc_r(7'h00, 0, 3, 0, 1));
      check("x3_via_x1", a_x1, 32'd8);
      pc_before = m_pc[0];
      issue(0, 32'h0000_2083);
      check("load_illegal_x1", a_x1, 32'd8);
      check("load_illegal_pc", a_pc, 32'(pc_before + 64'd4));
      issue(0, enc_i(12'd7, 0, 0, 0, 7'b0010011));
      issue(0, enc_r(7'h00, 0, 0, 0, 1));
      check("x0_reads_zero", a_x1, 32'd0);

      pc_before = m_pc[0];
      repeat (5) begin
         @(negedge clk);
         check("idle_ready", a_ready, 1);
         check("idle_pc", a_pc, 32'(pc_before));
         check("idle_retire", a_retire, 0);
      end

      // Load x1 with a nonzero value, then abandon ADDI x1,x0,9 by resetting during EXEC.
      issue(0, enc_i(12'd3, 0, 0, 1, 7'b0010011));
      @(negedge clk);
      a_valid = 1'b1; a_instr = enc_i(12'd9, 0, 0, 1, 7'b0010011);
      @(posedge clk); #1;
      a_valid = 1'b0;
      @(negedge clk);
      a_rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_retire", a_retire, 0);
      @(negedge clk);
      a_rst = 1'b0;
      reset_model(0);
      repeat (3) begin
         @(posedge clk); #1;
         check("midrst_no_retire", a_retire, 0);
         check("midrst_x1", a_x1, 32'd0);
         check("midrst_pc", a_pc, 32'd0);
      end

      for (int i = 0; i < 200; i++) issue(0, rand_instr(0));

      do_reset(1);
      issue(1, enc_i(12'd1, 0, 0, 1, 7'b0010011));
      check("pc_wrap", b_pc, 64'd0);
      issue(1, enc_i(12'd63, 1, 1, 1, 7'b0010011));
      check("slli63", b_x1, 64'h8000_0000_0000_0000);
      issue(1, enc_i(12'h428, 1, 5, 1, 7'b0010011));
      check("srai40", b_x1, 64'hFFFF_FFFF_FF80_0000);
      issue(1, enc_i(12'd1, 0, 0, 20, 7'b0010011));
      check("idx20_illegal_x1", b_x1, 64'hFFFF_FFFF_FF80_0000);
      for (int i = 0; i < 80; i++) issue(1, rand_instr(1));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/multicycle_core.md
# multicycle_core

Parametrised multi-cycle successor to the single-cycle integer datapath. Accepts one 32-bit RV32I-subset instruction per valid/ready handshake and runs it through a FETCH/EXEC/WB state machine against an internal register file. Supports immediate and register-register ALU ops, LUI, and BEQ/BNE branches that redirect the PC. Sits between the instruction source (memory or testbench) and the debug outputs.

## Interface
- XLEN, 32: datapath, register and PC width; must be ≥32 and a power of two.
- NREGS, 32: architectural registers; must be 16 or 32; x0 is hardwired to zero.
- RESET_PC, 0: PC value after reset.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  `instr` holds a valid instruction.
- instr  in  32  RV32I-encoded instruction.
- instr_ready  out  1  core can accept an instruction this cycle.
- pc_address  out  XLEN  PC of the instruction being or next to be executed.
- alu_output  out  XLEN  registered ALU result of the last executed instruction.
- reg1_output  out  XLEN  current contents of x1, for debug.
- retire  out  1  one-cycle pulse in WB.
- illegal  out  1  pulses with `retire` when the instruction was unsupported.

## Operation
- **FETCH**
  - `instr_ready` = 1.
  - On `instr_valid && instr_ready`, latch `instr` into IR, then go to EXEC.
  - Otherwise stay in FETCH.
- **EXEC**
  - Decode IR.
  - Read rs1 and rs2 (register index width is log2(NREGS); an index ≥ NREGS is illegal).
  - Compute the ALU result and branch decision, latch both, then go to WB.
- **WB**
  - Write the result to rd if the instruction writes, rd≠0, and it is not illegal.
  - Update the PC.
  - Pulse `retire`, then go to FETCH.
- **Supported opcodes**
  - OP-IMM 0010011: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - OP 0110011: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - LUI 0110111.
  - BRANCH 1100011: funct3 000 = BEQ, 001 = BNE.
- **Illegal instructions**: anything else, including unsupported funct3/funct7 or other branch funct3.
  - No register write.
  - PC += 4.
  - `illegal` = 1 with `retire`.
  - `alu_output` holds its previous value.
- **Immediates**: I, U and B formats, sign-extended to XLEN.
  - LUI result = sign-extended {imm[31:12], 12'b0}.
- **Shifts**: amount = low log2(XLEN) bits of operand B. SRA/SRAI are arithmetic.
- **PC update**
  - Taken branch: PC = PC + B-imm.
  - Otherwise: PC = PC + 4.
  - All arithmetic is modulo 2^XLEN, so the PC wraps silently.
- **Branches**: `alu_output` = rs1 − rs2.
- **Register read semantics**: reads in EXEC see all writes from earlier WB cycles (no bypass needed, writes are complete).
- **x0**: reads return 0; writes are discarded.

## Timing
- **Reset** (rst high at an edge):
  - State → FETCH.
  - `pc_address` = RESET_PC; `alu_output`, all registers and IR = 0.
  - `retire` = `illegal` = 0.
  - `instr_ready` is forced 0 while `rst` is high.
- **Reset mid-operation**: an instruction in EXEC or WB is abandoned with no register write, PC update or retire.
- **Latency**
  - Instruction accepted at edge N.
  - `retire` is high in the cycle after edge N+1.
  - The register write and PC update take effect at edge N+2.
  - Next acceptance is possible at edge N+3 at the earliest.
  - Throughput is 1 instruction per 3 cycles with `instr_valid` held high.
- `instr_ready` is low in EXEC and WB. The source must hold `instr` stable until the handshake.
- `pc_address` changes only at the WB edge or on reset. It is stable while `instr_ready` is high.
- `reg1_output` reflects an x1 write from the edge after WB.

## Structure
- **Package `core_pkg`**
  - Opcode constants.
  - funct3/funct7 constants.
  - ALU op enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB).
  - FSM state enum (FETCH, EXEC, WB).
- **Sub-module `core_alu`**
  - Combinational, parametrised by XLEN.
  - Inputs: operand A, operand B, ALU op.
  - Outputs: result and zero flag (used for BEQ/BNE).
- The register file and decode stay inline in `multicycle_core`.

## Test plan
- **Reset**: rst held 2 cycles with instr_valid=1 → instr_ready=0, pc_address=RESET_PC, alu_output=0, no retire.
- **ADDI then register ops**:
  - ADDI x1,x0,5 (0x00500093), then ADDI x2,x0,-3, then SUB x3,x1,x2.
  - Expected: reg1_output=5; x3=8; alu_output=8; pc_address=RESET_PC+12; three retire pulses spaced 3 cycles apart.
- **Branch taken and not taken**:
  - With x1=5, BEQ x1,x1,+16 → pc advances by 16.
  - BNE x1,x1,+16 → pc advances by 4.
  - Neither writes a register.
- **Illegal and x0 write**:
  - Opcode 0000011 (load) → illegal pulses with retire, pc+4, registers unchanged.
  - ADDI x0,x0,7 → x0 still reads 0.
- **Handshake and reset mid-instruction**:
  - instr_valid low for 5 cycles → stays in FETCH, pc_address unchanged.
  - rst pulsed during EXEC of ADDI x1,x0,9 → x1 stays 0, no retire.
- **Width parameter and wrap**:
  - XLEN=64, NREGS=16.
  - SRAI by 40 of 0x8000_0000_0000_0000 → 0xFFFF_FFFF_FF80_0000.
  - RESET_PC=2^64−4, no branch → pc wraps to 0.
  - A register index 20 → illegal.
